// File: rtl/y86_mem_arbiter.sv
// Two-port arbiter for the shared y86 memory bus: one access per grant,
// round-robin or fixed priority, with an owner lock for atomic sequences.
module y86_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 0,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic [AW-1:0] bus_A,
  output logic [DW-1:0] bus_out,
  output logic          bus_WE,
  output logic          bus_RE,
  input  logic [DW-1:0] bus_in
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT} state_t;

  state_t        state_q;
  logic          owner_q;
  logic          last_q;
  logic          lock_q;
  logic          we_q;
  logic [CW-1:0] wait_q;

  logic          owner_lock_c;
  logic          hold_c;
  logic          elig0_c;
  logic          elig1_c;
  logic          win_c;
  logic          win_we_c;
  logic          win_lock_c;
  logic [AW-1:0] win_addr_c;
  logic [DW-1:0] win_wdata_c;

  // Winner selection, only acted on in IDLE; a held lock excludes the non-owner.
  always_comb begin
    owner_lock_c = owner_q ? p1_lock : p0_lock;
    hold_c       = lock_q && owner_lock_c;
    elig0_c      = p0_req && !(hold_c && owner_q);
    elig1_c      = p1_req && !(hold_c && !owner_q);
    win_c        = elig1_c;
    if (elig0_c && elig1_c) begin
      win_c = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
    win_we_c    = win_c ? p1_we    : p0_we;
    win_lock_c  = win_c ? p1_lock  : p0_lock;
    win_addr_c  = win_c ? p1_addr  : p0_addr;
    win_wdata_c = win_c ? p1_wdata : p0_wdata;
  end

  // Access sequencer with all bus and requester outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      we_q      <= 1'b0;
      wait_q    <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      bus_A     <= '0;
      bus_out   <= '0;
      bus_WE    <= 1'b0;
      bus_RE    <= 1'b0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lock_q && !owner_lock_c) lock_q <= 1'b0;
          if (elig0_c || elig1_c) begin
            owner_q <= win_c;
            last_q  <= win_c;
            lock_q  <= win_lock_c;
            we_q    <= win_we_c;
            bus_A   <= win_addr_c;
            bus_WE  <= win_we_c;
            bus_RE  <= !win_we_c;
            bus_out <= win_we_c ? win_wdata_c : '0;
            p0_gnt  <= !win_c;
            p1_gnt  <= win_c;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (we_q || RD_LAT == 0) begin
            if (!we_q) begin
              if (owner_q) begin
                p1_rdata  <= bus_in;
                p1_rvalid <= 1'b1;
              end else begin
                p0_rdata  <= bus_in;
                p0_rvalid <= 1'b1;
              end
            end
            bus_A   <= '0;
            bus_out <= '0;
            bus_WE  <= 1'b0;
            bus_RE  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wait_q  <= CW'(RD_LAT - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            if (owner_q) begin
              p1_rdata  <= bus_in;
              p1_rvalid <= 1'b1;
            end else begin
              p0_rdata  <= bus_in;
              p0_rvalid <= 1'b1;
            end
            bus_A   <= '0;
            bus_RE  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Scoreboard bench: three arbiter variants (RR/lat0, RR/lat2, fixed/lat0) share
// stimulus; a negedge monitor checks the selected variant against queued expectations.
module tb_y86_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, bus_in;
  logic [2:0]  gnt0, gnt1, rv0, rv1, bwe, bre;
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic [31:0] ba  [3];
  logic [31:0] bo  [3];
  int          sel;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    y86_mem_arbiter #(
      .AW(32), .DW(32),
      .RD_LAT((g == 1) ? 2 : 0),
      .FIXED_PRIO((g == 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(gnt0[g]), .p0_rdata(rd0[g]), .p0_rvalid(rv0[g]),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(gnt1[g]), .p1_rdata(rd1[g]), .p1_rvalid(rv1[g]),
      .bus_A(ba[g]), .bus_out(bo[g]), .bus_WE(bwe[g]), .bus_RE(bre[g]), .bus_in(bus_in)
    );
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned cyc;
  } gnt_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int unsigned cyc;
  } rv_t;

  gnt_t        gq[$];
  rv_t         rq[$];
  int          checks = 0;
  int          errors = 0;
  int          hold_left = 0;
  logic [31:0] hold_addr = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_gnt(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned c);
    gnt_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic exp_rv(input logic port, input logic [31:0] data, input int unsigned c);
    rv_t e;
    e.port = port; e.data = data; e.cyc = c;
    rq.push_back(e);
  endtask

  function automatic int lat_of(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  // Monitor: every grant/rvalid must match the queue head; bus must be quiet otherwise.
  always @(negedge clk) begin
    gnt_t g;
    rv_t  r;
    if (!rst) begin
      hold_left = 0;
      chk("reset_strobes", 96'({gnt0[sel], gnt1[sel], rv0[sel], rv1[sel], bwe[sel], bre[sel]}), 96'(0));
      chk("reset_bus", 96'({ba[sel], bo[sel]}), 96'(0));
    end else begin
      if (gnt0[sel] || gnt1[sel]) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: got p0=%0b p1=%0b expected none (cycle %0d)",
                   gnt0[sel], gnt1[sel], cyc);
        end else begin
          g = gq.pop_front();
          chk("gnt_port", 96'({gnt0[sel], gnt1[sel]}), 96'(g.port ? 2'b01 : 2'b10));
          chk("gnt_cycle", 96'(cyc), 96'(g.cyc));
          chk("acc_strobes", 96'({bwe[sel], bre[sel]}), 96'(g.we ? 2'b10 : 2'b01));
          chk("acc_addr", 96'(ba[sel]), 96'(g.addr));
          if (g.we) chk("acc_wdata", 96'(bo[sel]), 96'(g.wdata));
          else begin
            hold_left = lat_of(sel);
            hold_addr = g.addr;
          end
        end
      end else if (hold_left > 0) begin
        chk("wait_strobes", 96'({bwe[sel], bre[sel]}), 96'(2'b01));
        chk("wait_addr", 96'(ba[sel]), 96'(hold_addr));
        hold_left--;
      end else begin
        chk("idle_bus", 96'({bwe[sel], bre[sel], ba[sel], bo[sel]}), 96'(0));
      end
      if (rv0[sel] || rv1[sel]) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got p0=%0b p1=%0b expected none (cycle %0d)",
                   rv0[sel], rv1[sel], cyc);
        end else begin
          r = rq.pop_front();
          chk("rv_port", 96'({rv0[sel], rv1[sel]}), 96'(r.port ? 2'b01 : 2'b10));
          chk("rv_cycle", 96'(cyc), 96'(r.cyc));
          chk("rv_data", 96'(r.port ? rd1[sel] : rd0[sel]), 96'(r.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    bus_in = '0;
  endtask

  task automatic do_reset(input int s);
    rst = 0;
    clear_inputs();
    sel = s;
    tick(); tick();
    rst = 1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t;
    rst = 0;
    sel = 0;
    clear_inputs();

    // Read, zero latency
    do_reset(0);
    t = cyc;
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; bus_in = 32'hDEADBEEF;
    exp_gnt(0, 0, 32'h10, 0, t + 1);
    exp_rv(0, 32'hDEADBEEF, t + 2);
    tick(); p0_req = 0;
    repeat (3) tick();

    // Write from port 1
    do_reset(0);
    t = cyc;
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h1234;
    exp_gnt(1, 1, 32'h20, 32'h1234, t + 1);
    tick(); p1_req = 0;
    repeat (3) tick();

    // Round-robin with both ports held
    do_reset(0);
    t = cyc;
    p0_req = 1; p0_we = 1; p0_addr = 32'h40; p0_wdata = 32'hA0;
    p1_req = 1; p1_we = 1; p1_addr = 32'h44; p1_wdata = 32'hA1;
    exp_gnt(0, 1, 32'h40, 32'hA0, t + 1);
    exp_gnt(1, 1, 32'h44, 32'hA1, t + 3);
    exp_gnt(0, 1, 32'h40, 32'hA0, t + 5);
    exp_gnt(1, 1, 32'h44, 32'hA1, t + 7);
    repeat (7) tick();
    p0_req = 0; p1_req = 0;
    repeat (3) tick();

    // Fixed priority: port 0 starves port 1 until it lets go
    do_reset(2);
    t = cyc;
    p0_req = 1; p0_we = 1; p0_addr = 32'h40; p0_wdata = 32'hA0;
    p1_req = 1; p1_we = 1; p1_addr = 32'h44; p1_wdata = 32'hA1;
    for (int i = 0; i < 4; i++) exp_gnt(0, 1, 32'h40, 32'hA0, t + 1 + 2 * i);
    exp_gnt(1, 1, 32'h44, 32'hA1, t + 9);
    repeat (7) tick();
    p0_req = 0;
    repeat (2) tick();
    p1_req = 0;
    repeat (3) tick();

    // Locked read-then-write by port 1 keeps port 0 out
    do_reset(0);
    t = cyc;
    p1_req = 1; p1_we = 0; p1_lock = 1; p1_addr = 32'h30; bus_in = 32'h0BADF00D;
    exp_gnt(1, 0, 32'h30, 0, t + 1);
    exp_rv(1, 32'h0BADF00D, t + 2);
    exp_gnt(1, 1, 32'h30, 32'h77, t + 3);
    exp_gnt(0, 1, 32'h50, 32'h55, t + 5);
    tick();
    p1_we = 1; p1_wdata = 32'h77;
    p0_req = 1; p0_we = 1; p0_addr = 32'h50; p0_wdata = 32'h55;
    repeat (2) tick();
    p1_req = 0; p1_lock = 0;
    repeat (2) tick();
    p0_req = 0;
    repeat (3) tick();

    // Two-cycle read latency; only the last WAIT-cycle data is captured
    do_reset(1);
    t = cyc;
    p0_req = 1; p0_we = 0; p0_addr = 32'h60; bus_in = 32'h11111111;
    exp_gnt(0, 0, 32'h60, 0, t + 1);
    exp_rv(0, 32'hCAFEF00D, t + 4);
    tick(); p0_req = 0; bus_in = 32'h22222222;
    tick(); bus_in = 32'h33333333;
    tick(); bus_in = 32'hCAFEF00D;
    tick(); bus_in = 32'h44444444;
    repeat (3) tick();

    // Reset during WAIT aborts the read; port 0 then wins the first contest
    do_reset(1);
    t = cyc;
    p0_req = 1; p0_we = 0; p0_addr = 32'h70; bus_in = 32'h99999999;
    exp_gnt(0, 0, 32'h70, 0, t + 1);
    tick(); p0_req = 0;
    tick();
    #2 rst = 0;
    #1 chk("async_abort", 96'({bre[1], bwe[1], ba[1]}), 96'(0));
    tick();
    rst = 1;
    tick();
    t = cyc;
    p0_req = 1; p0_we = 1; p0_addr = 32'h80; p0_wdata = 32'h8;
    p1_req = 1; p1_we = 1; p1_addr = 32'h84; p1_wdata = 32'h9;
    exp_gnt(0, 1, 32'h80, 32'h8, t + 1);
    exp_gnt(1, 1, 32'h84, 32'h9, t + 3);
    tick(); p0_req = 0;
    repeat (2) tick(); p1_req = 0;
    repeat (4) tick();

    chk("pending_gnt", 96'(gq.size()), 96'(0));
    chk("pending_rvalid", 96'(rq.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
